tug_key_pulser: RTL and testbench
=================================

Name: tug_key_pulser

Overview:
- Player-input front end for the tug-of-war game.
- Converts two raw, asynchronous, bouncing board pushbuttons into clean, synchronized, single-cycle move pulses `L` and `R`.
- These pulses drive every playfield light cell.
- Per-key flow: 2-flop synchronizer, then debounce FSM, then registered rising-edge pulse, gated by a game-enable input.

Parameters:
- `DB_CYCLES`, default 4: number of consecutive synchronized samples a key level must hold before it is accepted. Legal range 2..15.
- `CNT_W`, default 4: width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset. 0 resets all state immediately; the release is seen by the clock.
- `key_l_n`  input  1  raw left pushbutton, active-low (0 = pressed), asynchronous to `clk`.
- `key_r_n`  input  1  raw right pushbutton, active-low, asynchronous.
- `enable`  input  1  1 = game in play and pulses allowed; 0 = pulses suppressed (e.g. after a win).
- `L`  output  1  one-cycle pulse, 1 = accepted left press.
- `R`  output  1  one-cycle pulse, 1 = accepted right press.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - Both synchronizer stages load 1 (released).
  - Both FSMs go to IDLE; counters are 0.
  - `L` = 0 and `R` = 0 immediately.
- The two channels are identical and independent. `s` is the inverted second synchronizer stage (1 = pressed). `L` and `R` are registered outputs.
- Channel FSM states: IDLE, DB_PRESS, HELD, DB_REL. All transitions occur on the `clk` rising edge.
  - IDLE: `s` = 1 -> DB_PRESS, cnt <= 1. Otherwise stay, cnt <= 0.
  - DB_PRESS:
    - `s` = 0 -> IDLE, cnt <= 0. This is a glitch; no pulse.
    - `s` = 1 and cnt == DB_CYCLES-1 -> HELD, cnt <= 0, pulse <= `enable`.
    - `s` = 1 otherwise -> cnt <= cnt+1.
  - HELD: `s` = 0 -> DB_REL, cnt <= 1. Otherwise stay; no further pulses while held (no auto-repeat).
  - DB_REL:
    - `s` = 1 -> HELD, cnt <= 0, no pulse. This is release bounce.
    - `s` = 0 and cnt == DB_CYCLES-1 -> IDLE, cnt <= 0.
    - `s` = 0 otherwise -> cnt <= cnt+1.
- Pulse register: 1 only in the cycle following the DB_PRESS -> HELD edge; 0 in every other cycle.
- Latency: with the raw key stable-pressed before clk edge 0, the pulse is high for exactly one cycle, between edges DB_CYCLES+1 and DB_CYCLES+2.
- Minimum accepted press: DB_CYCLES consecutive pressed samples. Minimum gap between two accepted presses of one key: DB_CYCLES released samples.
- `enable` is sampled only at the DB_PRESS -> HELD edge.
  - A key that completes debounce while `enable` = 0 reaches HELD silently.
  - Raising `enable` while the key is held produces no pulse; the key must be released and pressed again.
- Simultaneous presses: channels are independent, so `L` and `R` may both be 1 in the same cycle. The light cells treat L&R as no move; this block does not arbitrate.
- Reset released while a key is held: the channel starts in IDLE with the synchronizer showing released. The key is seen as pressed after 2 cycles, debounces, and produces one pulse.
- Reset asserted mid-debounce or mid-pulse: outputs drop to 0 asynchronously and all state is lost; no pulse is generated on reset release.
- Counters never exceed DB_CYCLES-1. No wrap-around is possible.

Test Plan:
1. Reset: hold `reset` = 0 with both keys pressed -> `L` = `R` = 0 throughout. Release `reset` with `key_l_n` held at 0 and DB_CYCLES = 4 -> single `L` pulse 6 edges later, then `L` stays 0 while held.
2. Clean press: `enable` = 1, `key_l_n` = 0 for 10 cycles then 1 -> exactly one 1-cycle `L` pulse at edge 5 after assertion; `R` stays 0. Repeat with the right key for `R`.
3. Bounce: toggle `key_r_n` 0/1 every cycle for 8 cycles -> no `R` pulse. Then hold 0 for 6 cycles -> exactly one `R` pulse. Chatter during release of 1–3 cycles -> no second pulse.
4. Simultaneous: both keys asserted on the same cycle for 8 cycles -> `L` and `R` both 1 in the same single cycle.
5. Enable gating: `enable` = 0, press and hold L for 8 cycles -> no pulse. Set `enable` = 1 while still held -> no pulse. Release for 6 cycles and press again -> one `L` pulse.
6. Async reset mid-debounce: assert `reset` = 0 between clock edges two cycles into DB_PRESS -> `L` = 0 immediately. Release `reset` with the key released -> no pulse.

Source files
------------

// File: rtl/tug_key_pulser.sv
// Tug-of-war player input front end: two raw active-low pushbuttons become
// clean single-cycle move pulses L and R, suppressed while enable is low.

module tug_key_pulser_chan #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic enable,
  output logic o_pulse
);

  // state       | meaning
  // ST_IDLE     | key released and accepted as released
  // ST_DB_PRESS | key seen pressed, counting stable pressed samples
  // ST_HELD     | press accepted, waiting for release (no auto-repeat)
  // ST_DB_REL   | key seen released, counting stable released samples
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  logic             w_pressed;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pulse_nxt;

  // Synchronizer resets to the released level so a key held through reset
  // is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pressed) begin
          w_state_nxt = ST_DB_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_DB_PRESS: begin
        if (!w_pressed) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HELD;
          w_pulse_nxt = enable;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!w_pressed) begin
          w_state_nxt = ST_DB_REL;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_DB_REL: begin
        // A pressed sample here is release bounce: back to HELD, no pulse.
        if (w_pressed) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_pulse = r_pulse;

endmodule

module tug_key_pulser #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R
);

  logic w_pulse_l;
  logic w_pulse_r;

  tug_key_pulser_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_l (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_l_n),
    .enable  (enable),
    .o_pulse (w_pulse_l)
  );

  tug_key_pulser_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_r (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_r_n),
    .enable  (enable),
    .o_pulse (w_pulse_r)
  );

  assign L = w_pulse_l;
  assign R = w_pulse_r;

endmodule

// File: tb/tb_tug_key_pulser.sv
// Directed bench for tug_key_pulser with DB_CYCLES = 4: pulse counts and
// pulse positions per stimulus window are compared with hand-derived values.

module tb_tug_key_pulser;

  logic clk;
  logic reset;
  logic key_l_n;
  logic key_r_n;
  logic enable;
  logic L;
  logic R;

  int n_checks;
  int n_errors;

  int cnt_l, first_l, cnt_r, first_r;
  int acc_l, acc_r;

  tug_key_pulser #(
    .DB_CYCLES (4),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .enable  (enable),
    .L       (L),
    .R       (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles, sampling 1 time unit after each rising edge; index i is
  // the sample following the i-th edge of the window (i = 0 first).
  task automatic run(input int n, output int c_l, output int f_l,
                     output int c_r, output int f_r);
    c_l = 0; f_l = -1; c_r = 0; f_r = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (L === 1'b1) begin
        c_l++;
        if (f_l < 0) f_l = i;
      end
      if (R === 1'b1) begin
        c_r++;
        if (f_r < 0) f_r = i;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    key_l_n  = 1'b0;
    key_r_n  = 1'b0;
    enable   = 1'b1;

    // 1: reset held with both keys pressed, then released with L held
    #2;
    chk("reset_L", int'(L), 0);
    chk("reset_R", int'(R), 0);
    run(5, cnt_l, first_l, cnt_r, first_r);
    chk("reset_hold_pulses", cnt_l + cnt_r, 0);
    key_r_n = 1'b1;
    reset   = 1'b1;
    run(12, cnt_l, first_l, cnt_r, first_r);
    chk("rst_rel_L_count", cnt_l, 1);
    chk("rst_rel_L_pos", first_l, 5);
    chk("rst_rel_R_count", cnt_r, 0);
    key_l_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);
    chk("rst_rel_release", cnt_l + cnt_r, 0);

    // 2: clean presses on each key
    key_l_n = 1'b0;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("clean_L_count", cnt_l, 1);
    chk("clean_L_pos", first_l, 5);
    chk("clean_L_R_quiet", cnt_r, 0);
    key_l_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);
    chk("clean_L_release", cnt_l + cnt_r, 0);
    key_r_n = 1'b0;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("clean_R_count", cnt_r, 1);
    chk("clean_R_pos", first_r, 5);
    chk("clean_R_L_quiet", cnt_l, 0);
    key_r_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);
    chk("clean_R_release", cnt_l + cnt_r, 0);

    // 3: press bounce, settled press, release chatter
    acc_r = 0;
    for (int i = 0; i < 8; i++) begin
      key_r_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      run(1, cnt_l, first_l, cnt_r, first_r);
      acc_r += cnt_r;
    end
    chk("bounce_R_none", acc_r, 0);
    key_r_n = 1'b0;
    run(6, cnt_l, first_l, cnt_r, first_r);
    chk("bounce_settle_R_count", cnt_r, 1);
    chk("bounce_settle_R_pos", first_r, 5);
    acc_r = 0;
    for (int k = 1; k <= 3; k++) begin
      key_r_n = 1'b1;
      run(k, cnt_l, first_l, cnt_r, first_r);
      acc_r += cnt_r;
      key_r_n = 1'b0;
      run(1, cnt_l, first_l, cnt_r, first_r);
      acc_r += cnt_r;
    end
    key_r_n = 1'b1;
    run(10, cnt_l, first_l, cnt_r, first_r);
    acc_r += cnt_r;
    chk("rel_chatter_R_none", acc_r, 0);

    // 4: simultaneous presses
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    run(8, cnt_l, first_l, cnt_r, first_r);
    chk("simul_L_count", cnt_l, 1);
    chk("simul_R_count", cnt_r, 1);
    chk("simul_L_pos", first_l, 5);
    chk("simul_R_pos", first_r, 5);
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);

    // 5: enable gating
    enable  = 1'b0;
    key_l_n = 1'b0;
    run(8, cnt_l, first_l, cnt_r, first_r);
    chk("en0_press", cnt_l, 0);
    enable = 1'b1;
    run(6, cnt_l, first_l, cnt_r, first_r);
    chk("en_raised_held", cnt_l, 0);
    key_l_n = 1'b1;
    run(6, cnt_l, first_l, cnt_r, first_r);
    chk("en_release", cnt_l, 0);
    key_l_n = 1'b0;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("en_repress_count", cnt_l, 1);
    chk("en_repress_pos", first_l, 5);

    // Minimum release gap while L is held: 3 released samples are bounce,
    // 4 reach IDLE so the next press is accepted.
    key_l_n = 1'b1;
    run(3, cnt_l, first_l, cnt_r, first_r);
    key_l_n = 1'b0;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("gap3_no_pulse", cnt_l, 0);
    key_l_n = 1'b1;
    run(4, cnt_l, first_l, cnt_r, first_r);
    key_l_n = 1'b0;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("gap4_count", cnt_l, 1);
    chk("gap4_pos", first_l, 5);
    key_l_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);

    // Minimum press length: 3 pressed samples rejected, 4 accepted
    key_l_n = 1'b0;
    run(3, cnt_l, first_l, cnt_r, first_r);
    acc_l = cnt_l;
    key_l_n = 1'b1;
    run(8, cnt_l, first_l, cnt_r, first_r);
    acc_l += cnt_l;
    chk("press3_no_pulse", acc_l, 0);
    key_l_n = 1'b0;
    run(4, cnt_l, first_l, cnt_r, first_r);
    acc_l = cnt_l;
    key_l_n = 1'b1;
    run(2, cnt_l, first_l, cnt_r, first_r);
    chk("press4_count", acc_l + cnt_l, 1);
    chk("press4_pos", first_l, 1);
    run(8, cnt_l, first_l, cnt_r, first_r);

    // 6: async reset two cycles into DB_PRESS
    key_l_n = 1'b0;
    run(4, cnt_l, first_l, cnt_r, first_r);
    chk("mid_db_no_pulse_yet", cnt_l, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_db_reset_L", int'(L), 0);
    key_l_n = 1'b1;
    #1;
    reset = 1'b1;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("mid_db_after_rst", cnt_l + cnt_r, 0);

    // Async reset while the pulse is high
    key_l_n = 1'b0;
    run(6, cnt_l, first_l, cnt_r, first_r);
    chk("mid_pulse_L_high", int'(L), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_pulse_reset_L", int'(L), 0);
    key_l_n = 1'b1;
    #1;
    reset = 1'b1;
    run(10, cnt_l, first_l, cnt_r, first_r);
    chk("mid_pulse_after_rst", cnt_l + cnt_r, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
